rob_commit: RTL and testbench
=============================

# rob_commit

In-order retire stage at the read end of the reorder buffer: examines the entry at the ROB head each cycle and retires completed, exception-free entries (updating the architectural rename map and returning the displaced physical register to the free list). On an exception at the head it runs a flush sequence that redirects fetch and waits for rename recovery. Sits between the ROB table (read port) and the rename/free-list and fetch-redirect logic.

## Interface

Parameters
- ROB_TABLE_SIZE, 4, log2 of ROB depth (16 entries); pointers are ROB_TABLE_SIZE+1 bits (rob_ptr_t)

Ports
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- tail_ptr  in  rob_ptr_t  ROB tail pointer (next dispatch slot)
- head_entry  in  entry_t  ROB entry at head_ptr (combinational table read)
- head_ptr  out  rob_ptr_t  current head pointer, drives the ROB read address
- retire_valid  out  1  architectural map write: areg -> preg
- retire_areg  out  areg_addr_t  architectural register retired
- retire_preg  out  preg_addr_t  new physical mapping
- retire_pc  out  word_t  pc of retired instruction (debug/trace)
- free_valid  out  1  return opreg to free list
- free_preg  out  preg_addr_t  physical register freed (head_entry.opreg)
- free_ready  in  1  free list can accept a register this cycle
- flush  out  1  one-cycle pulse: squash pipeline and ROB
- flush_pc  out  word_t  pc of excepting instruction
- flush_exception  out  exception::exception_t  captured exception
- recover_done  in  1  rename tables restored; commit may resume
- commit_cnt  out  32  retired-instruction counter

## Operation

- Empty: head_ptr == tail_ptr (all ROB_TABLE_SIZE+1 bits). Full is the ROB's concern, not checked here.
- Exception present: any bit of head_entry.exception set.
- Needs free: head_entry.areg != 0.
- States: NORMAL, FLUSH, RECOVER.
- NORMAL, retire condition = !empty & complete & !exception & (free_ready | !needs_free):
  - retire_valid = needs_free; retire_areg/preg/pc from head_entry.
  - free_valid = needs_free; free_preg = head_entry.opreg.
  - head_ptr increments by 1 on the clock edge; the wrap bit toggles naturally at 2^ROB_TABLE_SIZE.
  - commit_cnt increments by 1 (wraps at 2^32).
- NORMAL, !empty & complete & exception: no retire, no free; capture pc and exception; next state FLUSH.
- NORMAL otherwise (empty, incomplete, or free_ready low when freeing is needed): hold; retire_valid = free_valid = 0.
- FLUSH: flush = 1 for exactly this one cycle; head_ptr <= 0; next state RECOVER.
- RECOVER: no retire; stay until recover_done = 1, then NORMAL. recover_done sampled in other states is ignored.
- retire_valid and free_valid are always equal; never asserted outside NORMAL.

## Timing

- retire_*, free_* are combinational from head_entry and state; head_ptr and commit_cnt update on the same edge that completes the retire (throughput 1/cycle).
- flush, flush_pc, flush_exception are registered: flush is high the cycle after the exception is seen at the head. flush_pc/flush_exception hold their value until the next capture.
- Minimum exception-to-resume: exception cycle, FLUSH, RECOVER (≥1 cycle), then retiring resumes.
- Reset (async, resetn = 0): state NORMAL, head_ptr 0, commit_cnt 0, flush 0, flush_pc 0, flush_exception 0; combinational outputs therefore 0 because tail_ptr is 0 at reset (empty). Reset asserted mid-FLUSH or mid-RECOVER returns to NORMAL immediately; no flush pulse is emitted.
- tail_ptr equal to head_ptr with the wrap bit differing = full, not empty; retire proceeds.

## Structure

- Add to rob_pkg: commit_state_t enum {NORMAL, FLUSH, RECOVER}; retire_req_t struct {valid, areg, preg, pc}; free_req_t struct {valid, preg}. Ports may be grouped using these types.
- Single module. No sub-module: the FSM and pointer logic are small enough to stay in one block.

## Test plan

- Reset then tail_ptr=0: no retire_valid, head_ptr=0, commit_cnt=0.
- Entry {complete=1, areg=5, preg=33, opreg=7, no exception}, tail_ptr=1, free_ready=1 -> retire_valid=1, areg 5->33, free_preg=7; next cycle head_ptr=1, commit_cnt=1.
- Same entry with free_ready=0 for 3 cycles -> no retire, head_ptr held at 0; retires in the cycle free_ready rises. areg=0 entry retires with free_ready=0 and both valids low.
- 20 back-to-back completed entries: head_ptr walks 0..15, then 16 (wrap bit set, index 0), ends at 20 (0b10100); commit_cnt=20.
- Head entry at pc 0xBFC00100 with an exception bit set -> next cycle flush=1 for one cycle, flush_pc=0xBFC00100, head_ptr=0; no retire until recover_done pulses; retires resume the following cycle.
- resetn dropped during RECOVER -> state NORMAL, flush=0, head_ptr=0, commit_cnt=0 asynchronously.

Source files
------------

// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Package  : exception / rob_pkg
// Brief    : Exception flags plus ROB entry, pointer and commit-stage types
// Revision : 1.0
// ============================================================================
package exception;
    typedef struct packed {
        logic bus_error;
        logic overflow;
        logic breakpoint;
        logic syscall;
        logic misaligned_store;
        logic misaligned_load;
        logic misaligned_fetch;
        logic illegal_instr;
    } exception_t;
endpackage

package rob_pkg;
    localparam int ROB_IDX_W = 4;
    localparam int AREG_W    = 5;
    localparam int PREG_W    = 6;

    typedef logic [ROB_IDX_W:0]  rob_ptr_t;
    typedef logic [AREG_W-1:0]   areg_addr_t;
    typedef logic [PREG_W-1:0]   preg_addr_t;
    typedef logic [31:0]         word_t;

    typedef struct packed {
        logic                  complete;
        exception::exception_t exception;
        areg_addr_t            areg;
        preg_addr_t            preg;
        preg_addr_t            opreg;
        word_t                 pc;
    } entry_t;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } commit_state_t;

    typedef struct packed {
        logic       valid;
        areg_addr_t areg;
        preg_addr_t preg;
        word_t      pc;
    } retire_req_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t preg;
    } free_req_t;

    function automatic logic has_exception(input exception::exception_t e);
        return |e;
    endfunction
endpackage
`default_nettype wire

// File: rtl/rob_commit_if.sv
`default_nettype none
// ============================================================================
// Interface : rob_commit_if
// Brief     : Commit stage <-> ROB table / rename / fetch-redirect signals
// Revision  : 1.0
// ============================================================================
interface rob_commit_if;
    import rob_pkg::*;

    rob_ptr_t              tail_ptr;
    entry_t                head_entry;
    rob_ptr_t              head_ptr;
    logic                  retire_valid;
    areg_addr_t            retire_areg;
    preg_addr_t            retire_preg;
    word_t                 retire_pc;
    logic                  free_valid;
    preg_addr_t            free_preg;
    logic                  free_ready;
    logic                  flush;
    word_t                 flush_pc;
    exception::exception_t flush_exception;
    logic                  recover_done;
    logic [31:0]           commit_cnt;

    // master: the commit stage itself
    modport master (
        input  tail_ptr, head_entry, free_ready, recover_done,
        output head_ptr, retire_valid, retire_areg, retire_preg, retire_pc,
               free_valid, free_preg, flush, flush_pc, flush_exception, commit_cnt
    );

    // slave: ROB table, rename/free-list and fetch side
    modport slave (
        output tail_ptr, head_entry, free_ready, recover_done,
        input  head_ptr, retire_valid, retire_areg, retire_preg, retire_pc,
               free_valid, free_preg, flush, flush_pc, flush_exception, commit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit
// Brief    : In-order ROB retire stage with exception flush/recover sequencing
// Revision : 1.0
// ============================================================================
module rob_commit
    import rob_pkg::*;
#(
    parameter int ROB_TABLE_SIZE = ROB_IDX_W
) (
    input  wire          clk,
    input  wire          resetn,
    rob_commit_if.master bus
);
    localparam int c_PTR_W = ROB_TABLE_SIZE + 1;

    commit_state_t         state_q, state_d;
    rob_ptr_t              head_ptr_q, head_ptr_d;
    logic [31:0]           commit_cnt_q, commit_cnt_d;
    logic                  flush_q, flush_d;
    word_t                 flush_pc_q, flush_pc_d;
    exception::exception_t flush_exc_q, flush_exc_d;

    retire_req_t           w_retire;
    free_req_t             w_free;
    logic                  w_empty;
    logic                  w_exc;
    logic                  w_needs_free;
    logic                  w_retiring;

    always_comb begin
        w_empty      = (head_ptr_q == bus.tail_ptr);
        w_exc        = has_exception(bus.head_entry.exception);
        w_needs_free = (bus.head_entry.areg != '0);

        state_d      = state_q;
        head_ptr_d   = head_ptr_q;
        commit_cnt_d = commit_cnt_q;
        flush_d      = 1'b0;
        flush_pc_d   = flush_pc_q;
        flush_exc_d  = flush_exc_q;
        w_retiring   = 1'b0;

        case (state_q)
            NORMAL: begin
                if (!w_empty && bus.head_entry.complete) begin
                    if (w_exc) begin
                        // flush_q is therefore high for exactly the FLUSH cycle
                        flush_d     = 1'b1;
                        flush_pc_d  = bus.head_entry.pc;
                        flush_exc_d = bus.head_entry.exception;
                        state_d     = FLUSH;
                    end else if (bus.free_ready || !w_needs_free) begin
                        w_retiring   = 1'b1;
                        head_ptr_d   = rob_ptr_t'(head_ptr_q + c_PTR_W'(1));
                        commit_cnt_d = commit_cnt_q + 32'd1;
                    end
                end
            end
            FLUSH: begin
                head_ptr_d = '0;
                state_d    = RECOVER;
            end
            RECOVER: begin
                if (bus.recover_done) begin
                    state_d = NORMAL;
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase

        // areg 0 has no architectural mapping, so it retires silently
        w_retire.valid = w_retiring && w_needs_free;
        w_retire.areg  = bus.head_entry.areg;
        w_retire.preg  = bus.head_entry.preg;
        w_retire.pc    = bus.head_entry.pc;
        w_free.valid   = w_retiring && w_needs_free;
        w_free.preg    = bus.head_entry.opreg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= NORMAL;
            head_ptr_q   <= '0;
            commit_cnt_q <= '0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
            flush_exc_q  <= '0;
        end else begin
            state_q      <= state_d;
            head_ptr_q   <= head_ptr_d;
            commit_cnt_q <= commit_cnt_d;
            flush_q      <= flush_d;
            flush_pc_q   <= flush_pc_d;
            flush_exc_q  <= flush_exc_d;
        end
    end

    assign bus.head_ptr        = head_ptr_q;
    assign bus.retire_valid    = w_retire.valid;
    assign bus.retire_areg     = w_retire.areg;
    assign bus.retire_preg     = w_retire.preg;
    assign bus.retire_pc       = w_retire.pc;
    assign bus.free_valid      = w_free.valid;
    assign bus.free_preg       = w_free.preg;
    assign bus.flush           = flush_q;
    assign bus.flush_pc        = flush_pc_q;
    assign bus.flush_exception = flush_exc_q;
    assign bus.commit_cnt      = commit_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_commit
// Brief    : Scoreboard bench: ROB model drives entries, monitor checks retires
// Revision : 1.0
// ============================================================================
module tb_rob_commit;
    import rob_pkg::*;

    typedef struct packed {
        areg_addr_t areg;
        preg_addr_t preg;
        preg_addr_t opreg;
        word_t      pc;
    } ret_exp_t;

    typedef struct packed {
        word_t                 pc;
        exception::exception_t exc;
    } flush_exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rob_commit_if bif();

    rob_commit #(.ROB_TABLE_SIZE(ROB_IDX_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    entry_t                rob_mem [16];
    rob_ptr_t              tail;
    ret_exp_t              exp_q[$];
    flush_exp_t            fexp_q[$];
    int                    vectors     = 0;
    int                    miscompares = 0;
    int                    model_cnt   = 0;
    int                    flush_seen  = 0;
    bit                    in_recover  = 1'b0;
    bit                    prev_flush  = 1'b0;
    word_t                 last_flush_pc  = '0;
    exception::exception_t last_flush_exc = '0;

    assign bif.tail_ptr   = tail;
    assign bif.head_entry = rob_mem[bif.head_ptr[ROB_IDX_W-1:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every visible retire must be the next expected one, in order
    always @(negedge clk) begin : mon
        ret_exp_t   re;
        flush_exp_t fe;
        if (resetn) begin
            if (in_recover) begin
                chk("recover_no_retire", 32'(bif.retire_valid), 32'd0);
                chk("recover_head", 32'(bif.head_ptr), 32'd0);
            end
            if (bif.retire_valid || bif.free_valid) begin
                chk("valid_pair", 32'(bif.free_valid), 32'(bif.retire_valid));
                chk("free_ready_on_retire", 32'(bif.free_ready), 32'd1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_retire: got areg %0d pc 0x%0h, expected none",
                             bif.retire_areg, bif.retire_pc);
                end else begin
                    re = exp_q.pop_front();
                    chk("retire_areg", 32'(bif.retire_areg), 32'(re.areg));
                    chk("retire_preg", 32'(bif.retire_preg), 32'(re.preg));
                    chk("free_preg", 32'(bif.free_preg), 32'(re.opreg));
                    chk("retire_pc", bif.retire_pc, re.pc);
                end
            end
            if (bif.flush) begin
                chk("flush_one_cycle", 32'(prev_flush), 32'd0);
                if (fexp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_flush: got pc 0x%0h, expected none", bif.flush_pc);
                end else begin
                    fe = fexp_q.pop_front();
                    chk("flush_pc", bif.flush_pc, fe.pc);
                    chk("flush_exception", 32'(bif.flush_exception), 32'(fe.exc));
                end
                flush_seen++;
            end
            prev_flush = bif.flush;
        end else begin
            prev_flush = 1'b0;
        end
    end

    function automatic entry_t rand_entry(input bit exc, input bit cmp);
        entry_t e;
        e.complete  = cmp;
        e.exception = exc ? exception::exception_t'(8'd1 << $urandom_range(0, 7)) : '0;
        e.areg      = ($urandom_range(0, 3) == 0) ? '0 : areg_addr_t'($urandom_range(1, 31));
        e.preg      = preg_addr_t'($urandom_range(0, 63));
        e.opreg     = preg_addr_t'($urandom_range(0, 63));
        e.pc        = word_t'($urandom) & 32'hFFFF_FFFC;
        return e;
    endfunction

    // Writes one ROB slot; entries that will retire get their expectation queued now
    task automatic dispatch(input entry_t e, input bit retires);
        rob_mem[tail[ROB_IDX_W-1:0]] = e;
        tail = rob_ptr_t'(tail + 1);
        if (retires) begin
            model_cnt++;
            if (e.areg != '0) exp_q.push_back(ret_exp_t'{e.areg, e.preg, e.opreg, e.pc});
        end
    endtask

    task automatic push_flush(input entry_t e);
        fexp_q.push_back(flush_exp_t'{e.pc, e.exception});
        last_flush_pc  = e.pc;
        last_flush_exc = e.exception;
    endtask

    task automatic do_reset();
        resetn           = 1'b0;
        tail             = '0;
        bif.free_ready   = 1'b0;
        bif.recover_done = 1'b0;
        in_recover       = 1'b0;
        foreach (rob_mem[i]) rob_mem[i] = '0;
        exp_q.delete();
        fexp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Runs until the ROB has drained; with exc, also squashes, refills one entry
    // during RECOVER and releases recovery after a random delay.
    task automatic drain(input bit exc, input bit rnd, input int max_cyc, input string tag);
        int     cyc       = 0;
        int     fs0       = flush_seen;
        int     rec_wait  = 0;
        bit     recovered = !exc;
        bit     done      = 1'b0;
        entry_t e;
        while (!done && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (in_recover) begin
                if (bif.recover_done) begin
                    bif.recover_done = 1'b0;
                    in_recover       = 1'b0;
                    recovered        = 1'b1;
                    if (!rnd) begin
                        @(negedge clk);
                        chk({tag, "_resume"}, 32'(bif.retire_valid), 32'd1);
                    end
                end else if (rec_wait == 0) begin
                    bif.recover_done = 1'b1;
                end else begin
                    rec_wait--;
                end
            end else if (exc && !recovered && flush_seen > fs0) begin
                bif.recover_done = 1'b0;
                tail = '0;
                foreach (rob_mem[i]) rob_mem[i] = '0;
                e      = rand_entry(1'b0, 1'b1);
                e.areg = areg_addr_t'($urandom_range(1, 31));
                dispatch(e, 1'b1);
                in_recover = 1'b1;
                rec_wait   = $urandom_range(0, 2);
            end else if (rnd) begin
                bif.recover_done = ($urandom_range(0, 7) == 0);
            end
            if (rnd) begin
                bif.free_ready = ($urandom_range(0, 3) != 0);
                rob_mem[$urandom_range(0, 15)].complete = 1'b1;
            end
            done = recovered && (bif.head_ptr == tail);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got head %0d tail %0d after %0d cycles, expected drained",
                     tag, bif.head_ptr, tail, cyc);
        end
        bif.recover_done = 1'b0;
        chk({tag, "_commit_cnt"}, bif.commit_cnt, 32'(model_cnt));
        chk({tag, "_retires_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_flushes_left"}, 32'(fexp_q.size()), 32'd0);
        if (exc) begin
            chk({tag, "_flush_pc_hold"}, bif.flush_pc, last_flush_pc);
            chk({tag, "_flush_exc_hold"}, 32'(bif.flush_exception), 32'(last_flush_exc));
        end
    endtask

    task automatic run_episode();
        int     n;
        int     xi;
        bit     ex;
        entry_t e;
        n  = $urandom_range(1, 16);
        ex = ($urandom_range(0, 2) == 0);
        xi = ex ? int'($urandom_range(0, n - 1)) : n;
        bif.free_ready = $urandom_range(0, 1) == 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            e = rand_entry(i == xi, $urandom_range(0, 1) == 1);
            if (i == xi) push_flush(e);
            dispatch(e, i < xi);
        end
        drain(ex, 1'b1, 800, "rand");
    endtask

    initial begin : stim
        entry_t e;
        int     cyc;
        int     fs0;

        do_reset();
        @(negedge clk);
        chk("rst_retire_valid", 32'(bif.retire_valid), 32'd0);
        chk("rst_head_ptr", 32'(bif.head_ptr), 32'd0);
        chk("rst_commit_cnt", bif.commit_cnt, 32'd0);
        chk("rst_flush", 32'(bif.flush), 32'd0);
        chk("rst_flush_pc", bif.flush_pc, 32'd0);

        // Single retire with free list ready
        e = '0;
        e.complete = 1'b1;
        e.areg = 5'd5; e.preg = 6'd33; e.opreg = 6'd7; e.pc = 32'h0000_1000;
        bif.free_ready = 1'b1;
        @(posedge clk); #1;
        dispatch(e, 1'b1);
        @(negedge clk);
        chk("single_retire_valid", 32'(bif.retire_valid), 32'd1);
        chk("single_free_preg", 32'(bif.free_preg), 32'd7);
        @(negedge clk);
        chk("single_head_ptr", 32'(bif.head_ptr), 32'd1);
        chk("single_commit_cnt", bif.commit_cnt, 32'd1);

        // Free list stalls the head for three cycles
        bif.free_ready = 1'b0;
        e.pc = 32'h0000_1004;
        @(posedge clk); #1;
        dispatch(e, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_retire_valid", 32'(bif.retire_valid), 32'd0);
            chk("stall_head_ptr", 32'(bif.head_ptr), 32'd1);
        end
        @(posedge clk); #1;
        bif.free_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(bif.retire_valid), 32'd1);
        @(negedge clk);
        chk("stall_head_after", 32'(bif.head_ptr), 32'd2);
        chk("stall_cnt_after", bif.commit_cnt, 32'd2);

        // areg 0 retires without a free-list slot
        bif.free_ready = 1'b0;
        e.areg = '0; e.pc = 32'h0000_1008;
        @(posedge clk); #1;
        dispatch(e, 1'b1);
        @(negedge clk);
        chk("areg0_retire_valid", 32'(bif.retire_valid), 32'd0);
        chk("areg0_free_valid", 32'(bif.free_valid), 32'd0);
        @(negedge clk);
        chk("areg0_head_ptr", 32'(bif.head_ptr), 32'd3);
        chk("areg0_commit_cnt", bif.commit_cnt, 32'd3);

        // 20 back-to-back retires across the pointer wrap
        do_reset();
        bif.free_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            e = rand_entry(1'b0, 1'b1);
            e.areg = areg_addr_t'($urandom_range(1, 31));
            @(posedge clk); #1;
            dispatch(e, 1'b1);
            @(negedge clk);
            chk("b2b_head_ptr", 32'(bif.head_ptr), 32'(k));
            chk("b2b_retire_valid", 32'(bif.retire_valid), 32'd1);
        end
        @(negedge clk);
        chk("b2b_final_head", 32'(bif.head_ptr), 32'b10100);
        chk("b2b_final_cnt", bif.commit_cnt, 32'd20);

        // Exception at the head: flush, recover, resume
        @(posedge clk); #1;
        e = rand_entry(1'b0, 1'b1);
        dispatch(e, 1'b1);
        e = rand_entry(1'b1, 1'b1);
        e.pc = 32'hBFC0_0100;
        push_flush(e);
        dispatch(e, 1'b0);
        e = rand_entry(1'b0, 1'b1);
        dispatch(e, 1'b0);
        drain(1'b1, 1'b0, 100, "exc");

        // Asynchronous reset while in RECOVER
        do_reset();
        bif.free_ready = 1'b1;
        fs0 = flush_seen;
        @(posedge clk); #1;
        e = rand_entry(1'b0, 1'b1); dispatch(e, 1'b1);
        e = rand_entry(1'b0, 1'b1); dispatch(e, 1'b1);
        e = rand_entry(1'b1, 1'b1); e.pc = 32'h0000_2000; push_flush(e); dispatch(e, 1'b0);
        cyc = 0;
        while (flush_seen == fs0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        chk("rstrec_flush_seen", 32'(flush_seen - fs0), 32'd1);
        #3;
        resetn = 1'b0;
        tail   = '0;
        #1;
        chk("rstrec_head_ptr", 32'(bif.head_ptr), 32'd0);
        chk("rstrec_commit_cnt", bif.commit_cnt, 32'd0);
        chk("rstrec_flush", 32'(bif.flush), 32'd0);
        chk("rstrec_flush_pc", bif.flush_pc, 32'd0);
        chk("rstrec_retire_valid", 32'(bif.retire_valid), 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        fexp_q.delete();
        model_cnt = 0;
        resetn    = 1'b1;
        e = rand_entry(1'b0, 1'b1);
        dispatch(e, 1'b1);
        drain(1'b0, 1'b0, 20, "rstrec_resume");

        for (int ep = 0; ep < 40; ep++) begin
            run_episode();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
